mux_scan_nx1: RTL
=================

Name: mux_scan_nx1

Overview:
Parametrised, registered N-channel to 1 multiplexer with a valid/ready output handshake. It is the sequential successor of the combinational 16x1 mux.
- Two modes: direct mode captures one selected channel per request; scan mode walks channels 0..N_CH-1 and emits one beat per channel.
- Used wherever a wide status or data bus is serialised onto a single narrow consumer.

Parameters:
- N_CH, 16, number of input channels (2..256).
- W, 1, width of each channel in bits.
- SEL_W, 4, width of sel and out_ch. Must satisfy 2**SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in  input  N_CH*W  packed channels; channel k is in[k*W +: W]
- mode  input  1  0 = direct, 1 = scan; sampled only with start
- sel  input  SEL_W  channel index for direct mode; sampled only with start
- start  input  1  request; honoured only in IDLE
- out_data  output  W  registered channel data
- out_ch  output  SEL_W  index of the channel currently in out_data
- out_valid  output  1  out_data/out_ch valid
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready
- sel_err  output  1  current beat came from an out-of-range sel
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on acceptance of the final beat

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; out_data, out_ch, out_valid, sel_err, busy and done are all 0. Reset overrides all other inputs.
- States: IDLE, HOLD (direct), SCAN.
- IDLE + start, mode=0:
  - out_data <= in[sel*W +: W]; out_ch <= sel; out_valid <= 1; go to HOLD.
  - If sel >= N_CH: out_data <= 0 and sel_err <= 1.
- IDLE + start, mode=1: out_data <= channel 0; out_ch <= 0; out_valid <= 1; go to SCAN.
- Latency: start sampled at edge k gives out_valid=1 from edge k onward, i.e. the data is visible in the following cycle.
- Hold rule: while out_valid && !out_ready, out_data, out_ch and sel_err stay stable. `in` changing has no effect on the held beat.
- HOLD + accept: out_valid <= 0, sel_err <= 0, done <= 1 for one cycle; go to IDLE.
- SCAN + accept on channel c < N_CH-1: capture channel c+1 from the current `in` on the same edge. out_valid stays 1, so with out_ready held high the block sustains one beat per cycle.
- SCAN + accept on channel N_CH-1: out_valid <= 0, done <= 1; go to IDLE.
- start while busy is ignored. start in the same cycle as the final accept is also ignored; a new request is only taken from IDLE.
- out_ch increments by exactly one per accepted scan beat and never exceeds N_CH-1.
- Reset mid-HOLD or mid-SCAN aborts the operation immediately with no done pulse.
- Back-to-back requests: the earliest re-start is in the cycle after done.

Optional Feature:
- Macro: MUX_SCAN_LOOP_EN.
- Defined:
  - In SCAN, accepting channel N_CH-1 wraps out_ch to 0 and captures channel 0. done pulses once per completed sweep.
  - mode is re-sampled at each wrap: mode=0 ends the scan (out_valid <= 0, go to IDLE); mode=1 continues.
- Not defined: single sweep as described in Behaviour. mode is ignored outside start.

Test Plan:
- Reset: N_CH=16, W=1, rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, no done.
- Direct mode: in=16'b1010_1100_1111_0001, out_ready=1, start with sel = 0, 1, 2, 5, 10, 15 in turn -> out_data = 1, 0, 0, 1, 1, 1; one done per request; sel_err=0.
- Scan throughput: same `in`, mode=1, out_ready held at 1 -> 16 consecutive beats, out_data = 1,0,0,0,1,1,1,1,0,0,1,1,0,1,0,1 on out_ch 0..15; done pulses on the beat with out_ch=15; busy=0 the next cycle.
- Backpressure: scan with out_ready=0 for 3 cycles at out_ch=4 while `in` is toggled -> out_data and out_ch stay frozen at the value captured for channel 4; the sweep then resumes at out_ch=5.
- Out-of-range sel and busy start: N_CH=5, W=8, sel=6 -> out_data=8'h00, sel_err=1. A second start pulse while out_valid=1 is ignored.
- Reset mid-scan: rst=1 at out_ch=7 -> outputs cleared, no done. With MUX_SCAN_LOOP_EN and mode held at 1: out_ch wraps 15 -> 0 and done pulses once per sweep; dropping mode before the wrap gives IDLE after out_ch=15.

Source files
------------

// File: rtl/mux_scan_nx1_if.sv
// -----------------------------------------------------------------------------
// mux_scan_nx1_if
// Bundles the channel bus, the request controls and the valid/ready output
// beat of mux_scan_nx1.
//
// Parameters must match the mux_scan_nx1 instance that is connected:
//   N_CH  : number of input channels
//   W     : bits per channel
//   SEL_W : width of sel / out_ch, 2**SEL_W >= N_CH
//
// Signals:
//   in        : packed channels, channel k is in[k*W +: W]
//   mode      : 0 = direct, 1 = scan (sampled with start)
//   sel       : direct-mode channel index (sampled with start)
//   start     : request, honoured only when the mux is idle
//   out_data  : registered channel data
//   out_ch    : channel index of out_data
//   out_valid : out_data / out_ch valid
//   out_ready : consumer accepts the beat when out_valid && out_ready
//   sel_err   : current beat came from an out-of-range sel
//   busy      : mux is not idle
//   done      : one-cycle pulse on acceptance of the final beat
//
// Modports:
//   master : requester / consumer side
//   slave  : the mux itself
// -----------------------------------------------------------------------------
interface mux_scan_nx1_if #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4
);

  logic [N_CH*W-1:0] in;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic              start;

  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;
  logic              busy;
  logic              done;

  modport master (
    output in,
    output mode,
    output sel,
    output start,
    output out_ready,
    input  out_data,
    input  out_ch,
    input  out_valid,
    input  sel_err,
    input  busy,
    input  done
  );

  modport slave (
    input  in,
    input  mode,
    input  sel,
    input  start,
    input  out_ready,
    output out_data,
    output out_ch,
    output out_valid,
    output sel_err,
    output busy,
    output done
  );

endinterface : mux_scan_nx1_if

// File: rtl/mux_scan_nx1.sv
// -----------------------------------------------------------------------------
// mux_scan_nx1
// Registered N_CH-to-1 multiplexer with a valid/ready output beat. Serialises a
// wide status/data bus onto one narrow consumer.
//
//   direct mode : one request captures the channel chosen by sel, one beat.
//   scan mode   : one request walks channels 0..N_CH-1, one beat per channel,
//                 one beat per cycle while out_ready stays high.
//
// Build option:
//   MUX_SCAN_LOOP_EN  when defined, a scan wraps from channel N_CH-1 back to
//                     channel 0 while mode is high at the wrap; done pulses
//                     once per completed sweep. When undefined a scan is a
//                     single sweep and mode only matters together with start.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (overrides everything)
//   bus : mux_scan_nx1_if.slave (channel bus, request, output beat, status)
//
// State table:
//   state | meaning
//   IDLE  | no beat pending, waiting for start
//   HOLD  | direct-mode beat presented, waiting for acceptance
//   SCAN  | scan beat presented, walking the channels
// -----------------------------------------------------------------------------
module mux_scan_nx1 #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_nx1_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] CH_ZERO = '0;
  localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q,   sel_err_d;
  logic             done_q,      done_d;

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------
  // Indices can reach 2**SEL_W-1, which may lie beyond the last channel, so the
  // selection is an explicit compare per channel rather than a computed part
  // select; indices with no matching channel read as zero.
  function automatic logic [W-1:0] pick_ch(
    input logic [N_CH*W-1:0] vec,
    input logic [SEL_W-1:0]  idx
  );
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(idx) == k) begin
        r = vec[k*W +: W];
      end
    end
    return r;
  endfunction

  logic             accept;
  logic             sel_in_range;
  logic [SEL_W-1:0] next_ch;
  logic [W-1:0]     sel_data;
  logic [W-1:0]     next_data;
  logic [W-1:0]     ch0_data;

  assign accept       = out_valid_q & bus.out_ready;
  assign sel_in_range = (int'(bus.sel) < N_CH);
  assign next_ch      = out_ch_q + CH_ONE;
  assign sel_data     = pick_ch(bus.in, bus.sel);
  assign next_data    = pick_ch(bus.in, next_ch);
  assign ch0_data     = pick_ch(bus.in, CH_ZERO);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          out_valid_d = 1'b1;
          if (!bus.mode) begin
            out_ch_d = bus.sel;
            if (sel_in_range) begin
              out_data_d = sel_data;
              sel_err_d  = 1'b0;
            end else begin
              out_data_d = '0;
              sel_err_d  = 1'b1;
            end
            state_d = HOLD;
          end else begin
            out_ch_d   = CH_ZERO;
            out_data_d = ch0_data;
            sel_err_d  = 1'b0;
            state_d    = SCAN;
          end
        end
      end

      HOLD: begin
        if (accept) begin
          out_valid_d = 1'b0;
          sel_err_d   = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      SCAN: begin
        if (accept) begin
          if (out_ch_q == LAST_CH) begin
            done_d = 1'b1;
`ifdef MUX_SCAN_LOOP_EN
            // mode is looked at again only here, at the end of each sweep.
            if (bus.mode) begin
              out_ch_d   = CH_ZERO;
              out_data_d = ch0_data;
            end else begin
              out_valid_d = 1'b0;
              state_d     = IDLE;
            end
`else
            out_valid_d = 1'b0;
            state_d     = IDLE;
`endif
          end else begin
            // Capture the following channel on the accepting edge so a
            // continuously ready consumer sees one beat per cycle.
            out_ch_d   = next_ch;
            out_data_d = next_data;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        sel_err_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule : mux_scan_nx1
